// File: rtl/dmem_responder.sv
// dmem_responder: MEM-stage data memory with fixed-latency byte/half/word access
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_memReq,
  input  logic        i_memWrite,
  input  logic [1:0]  i_memSize,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_ack,
  output logic        o_busy,
  output logic        o_misalign
);
  localparam int AW = $clog2(DEPTH_WORDS);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, state_n;
  logic [3:0] cnt;
  logic [AW+1:0] q_addr, a_addr;
  logic [1:0] q_size, a_size;
  logic q_write, a_write, direct, do_access, bad;
  logic [31:0] q_wdata, a_wdata, old_word, lane_mask, size_mask, rd_val, wr_word;
  logic [4:0] sh;
  logic [31:0] mem [DEPTH_WORDS];
  always_comb begin
    direct = state == IDLE;
    a_addr = direct ? i_addr[AW+1:0] : q_addr;
    a_size = direct ? i_memSize : q_size;
    a_write = direct ? i_memWrite : q_write;
    a_wdata = direct ? i_wdata : q_wdata;
    sh = {a_addr[1:0], 3'b000};
    bad = a_size == 2'b11 || (a_size == 2'b01 && a_addr[0]) || (a_size == 2'b10 && a_addr[1:0] != 2'b00);
    size_mask = a_size == 2'b00 ? 32'h0000_00FF : a_size == 2'b01 ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    lane_mask = size_mask << sh;
    old_word = mem[a_addr[AW+1:2]];
    rd_val = (old_word >> sh) & size_mask;
    wr_word = (old_word & ~lane_mask) | ((a_wdata << sh) & lane_mask);
    do_access = (state == IDLE && i_memReq && LATENCY == 1) || (state == WAIT && cnt == 4'd1);
    state_n = state == IDLE ? (i_memReq ? (LATENCY == 1 ? RESP : WAIT) : IDLE)
            : state == WAIT ? (cnt == 4'd1 ? RESP : WAIT) : IDLE;
    o_busy = (state == IDLE && i_memReq) || state == WAIT;
    o_ack = state == RESP;
  end
  always_ff @(posedge clk) state <= reset ? IDLE : state_n;
  always_ff @(posedge clk)
    if (reset) begin
      cnt <= '0;
      q_addr <= '0;
      q_size <= '0;
      q_write <= 1'b0;
      q_wdata <= '0;
      o_rdata <= '0;
      o_misalign <= 1'b0;
    end else begin
      if (state == IDLE && i_memReq) begin
        cnt <= 4'(LATENCY - 1);
        q_addr <= i_addr[AW+1:0];
        q_size <= i_memSize;
        q_write <= i_memWrite;
        q_wdata <= i_wdata;
      end else if (state == WAIT) cnt <= cnt - 4'd1;
      if (do_access) begin
        o_rdata <= (a_write || bad) ? '0 : rd_val;
        o_misalign <= bad;
      end
    end
  always_ff @(posedge clk)
    if (do_access && !reset && a_write && !bad) mem[a_addr[AW+1:2]] <= wr_word;
endmodule
